// File: rtl/fp_div_pkg.sv
// fp_div_pkg
//   Shared definitions for the floating-point division datapath.
//   - div_state_t : sequencer states of the mantissa divider
//   - MANT_W      : mantissa width including the hidden bit
//   - QUO_W       : quotient bits produced (mantissa + guard + round)
//   - cnt_width() : width of an iteration counter that must hold n-1
package fp_div_pkg;

  localparam int MANT_W = 24;
  localparam int QUO_W  = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to count down from n-1 to 0; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/div_step_sub.sv
// div_step_sub
//   Combinational ripple-borrow subtractor used as the single shared
//   subtract step of the iterative divider.
//   Ports:
//     a      : minuend (partial remainder)
//     b      : subtrahend (zero-extended divisor)
//     out    : a - b, modulo 2**W
//     borrow : 1 when a < b (the step must be restored)
module div_step_sub
  import fp_div_pkg::*;
#(
  parameter int W = MANT_W + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         borrow
);

  logic [W:0] bw;

  always_comb begin
    bw    = '0;
    out   = '0;
    for (int i = 0; i < W; i++) begin
      out[i]   = a[i] ^ b[i] ^ bw[i];
      // Borrow out of this bit: a=0,b=1, or a==b with a borrow coming in.
      bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
    borrow = bw[W];
  end

endmodule

// File: rtl/mant_div_seq.sv
// mant_div_seq
//   Sequential restoring divider for single-precision mantissas. One
//   quotient bit per cycle: QW bits (integer bit, fraction, guard, round)
//   plus a sticky bit reflecting a nonzero final remainder.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : request, only honoured in IDLE
//     abort      : synchronous flush to IDLE, beats start and RUN/DONE
//     dividend   : normalized dividend mantissa
//     divisor    : normalized divisor mantissa (MSB must be 1)
//     busy       : operation in flight (RUN or DONE)
//     done       : one-cycle pulse, quotient/sticky/err valid
//     quotient   : bit QW-1 is the integer bit
//     sticky     : final partial remainder nonzero
//     err        : divisor MSB was 0 on the accepted start
//     dbg_state  : current sequencer state for observation
//   Handshake: start is a level sampled only in IDLE; there is no ready,
//   a start while busy is dropped. Each accepted start produces exactly one
//   done pulse unless it is aborted or reset; results hold until the next
//   completed operation.
module mant_div_seq
  import fp_div_pkg::*;
#(
  parameter int MW = MANT_W,
  parameter int QW = QUO_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [MW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          err,
  output div_state_t    dbg_state
);

  localparam int CW = cnt_width(QW);

  div_state_t    state;
  logic [MW:0]   rem;
  logic [MW-1:0] dreg;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;
  // err is staged here and only published with done, so an aborted
  // operation leaves the previously reported err untouched.
  logic          err_pend;

  logic [MW:0]   diff;
  logic          borrow;

  div_step_sub #(.W(MW + 1)) u_step (
    .a      (rem),
    .b      ({1'b0, dreg}),
    .out    (diff),
    .borrow (borrow)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      sticky   <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      rem      <= '0;
      dreg     <= '0;
      q        <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              q    <= '0;
              if (divisor[MW-1]) begin
                rem      <= {1'b0, dividend};
                dreg     <= divisor;
                cnt      <= CW'(QW - 1);
                err_pend <= 1'b0;
                state    <= RUN;
              end else begin
                // Unnormalized divisor: skip iteration, report zero result.
                rem      <= '0;
                err_pend <= 1'b1;
                state    <= DONE;
              end
            end
          end
          RUN: begin
            // rem < 2*dreg keeps the shifted value within MW+1 bits.
            if (borrow) rem <= {rem[MW-1:0], 1'b0};
            else        rem <= {diff[MW-1:0], 1'b0};
            q   <= {q[QW-2:0], ~borrow};
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= DONE;
          end
          DONE: begin
            done     <= 1'b1;
            quotient <= q;
            sticky   <= |rem;
            err      <= err_pend;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mant_div_seq.sv
module tb_mant_div_seq;
  import fp_div_pkg::*;

  localparam int MW = MANT_W;
  localparam int QW = QUO_W;
  localparam int EW = QW + 2;   // {quotient, sticky, err}

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [MW-1:0] dividend;
  logic [MW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [QW-1:0] quotient;
  logic          sticky;
  logic          err;
  div_state_t    dbg_state;

  mant_div_seq #(.MW(MW), .QW(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .sticky    (sticky),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic [EW-1:0] mon_e;
  int n_checks;
  int n_fail;
  int done_seen;
  logic saw_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: restoring division yields floor(N * 2^(QW-1) / D).
  function automatic logic [EW-1:0] model(input logic [MW-1:0] dd, input logic [MW-1:0] dv);
    logic [63:0] num, qq, rr;
    if (!dv[MW-1]) return {{QW{1'b0}}, 1'b0, 1'b1};
    num = 64'(dd) << (QW - 1);
    qq  = num / 64'(dv);
    rr  = num % 64'(dv);
    return {qq[QW-1:0], (rr != 0), 1'b0};
  endfunction

  always @(posedge clk) begin
    #1;
    if (dbg_state == RUN) saw_run = 1'b1;
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(mon_e[EW-1:2]));
        check("sticky",   32'(sticky),   32'(mon_e[1]));
        check("err",      32'(err),      32'(mon_e[0]));
        last_exp = mon_e;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [MW-1:0] dd, input logic [MW-1:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    exp_q.push_back(model(dd, dv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the first edge after the start edge until done.
  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 200);
    check("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic run_op(input logic [MW-1:0] dd, input logic [MW-1:0] dv);
    saw_run = 1'b0;
    start_op(dd, dv);
    check("busy_run", 32'(busy), 32'd1);
    wait_done(dv[MW-1] ? QW + 1 : 1);
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    logic [MW-1:0] rdd, rdv;
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    saw_run   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #1;
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_quotient", 32'(quotient),  32'd0);
    check("rst_sticky",   32'(sticky),    32'd0);
    check("rst_err",      32'(err),       32'd0);
    check("rst_state",    32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    run_op(24'h800000, 24'h800000);
    check("q_1_1", 32'(quotient), 32'h2000000);
    run_op(24'hC00000, 24'h800000);
    check("q_15_1", 32'(quotient), 32'h3000000);
    run_op(24'h800000, 24'hC00000);
    check("q_1_15", 32'(quotient), 32'h1555555);
    check("s_1_15", 32'(sticky), 32'd1);
    run_op(24'hFFFFFF, 24'h800000);
    check("q_max_min", 32'(quotient), 32'h3FFFFFC);
    run_op(24'hFFFFFF, 24'hFFFFFF);
    check("q_max_max", 32'(quotient), 32'h2000000);
    // Unnormalized dividend: integer bit 0.
    run_op(24'h400000, 24'h800000);
    check("q_unnorm", 32'(quotient), 32'h1000000);

    // Error path.
    run_op(24'h800000, 24'h400000);
    check("err_flag", 32'(err), 32'd1);
    check("err_q", 32'(quotient), 32'd0);
    check("err_no_run", 32'(saw_run), 32'd0);

    // Random normalized operands.
    for (int i = 0; i < 6; i++) begin
      rdd = {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
      rdv = {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
      run_op(rdd, rdv);
    end
    check("err_cleared", 32'(err), 32'd0);

    // start pulsed again at cycle 5 of a run is ignored.
    start_op(24'h800000, 24'hC00000);
    repeat (4) @(negedge clk);
    dividend = 24'hFFFFFF;
    divisor  = 24'h800000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(QW + 1 - 5);
    check("ignored_start_q", 32'(quotient), 32'h1555555);
    repeat (35) @(negedge clk);
    check("ignored_start_queue", 32'(exp_q.size()), 32'd0);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    dividend = 24'hC00000;
    divisor  = 24'h800000;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_state", 32'(dbg_state), 32'(IDLE));
    check("abort_start_busy", 32'(busy), 32'd0);

    // Abort at cycle 10: no done, previous results retained.
    start_op(24'hFFFFFF, 24'h800000);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    snap = done_seen;
    repeat (35) @(negedge clk);
    check("abort_no_done", 32'(done_seen), 32'(snap));
    check("abort_keep_q", 32'(quotient), 32'h1555555);
    check("abort_keep_s", 32'(sticky), 32'd1);
    check("abort_keep_e", 32'(err), 32'd0);

    // Reset asserted mid-cycle at cycle 12: outputs clear at once.
    start_op(24'hFFFFFF, 24'hFFFFFF);
    void'(exp_q.pop_back());
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_sticky",   32'(sticky),   32'd0);
    check("arst_busy",     32'(busy),     32'd0);
    check("arst_state",    32'(dbg_state), 32'(IDLE));
    snap = done_seen;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    check("arst_no_done", 32'(done_seen), 32'(snap));

    // Fresh operation after reset.
    run_op(24'hC00000, 24'h800000);
    check("post_rst_q", 32'(quotient), 32'h3000000);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
